dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter and sequencer for the single-port data memory (DM) behind the pipeline CPU. It shares DM between the pipeline's MEM stage and a debug/loader port, and holds each transaction for a fixed memory latency. It drives a stall to the pipeline while the MEM-stage access is pending. It sits between the EX_MEM register outputs and DM, replacing the direct MEM-stage-to-DM connection.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, DM occupancy per access in cycles (legal 1..15)

- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- cpu_req  input  1  MEM-stage access request; held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  byte address, word aligned
- cpu_wdata  input  DATA_W  write data
- cpu_rdata  output  DATA_W  registered read data, valid while cpu_ack = 1
- cpu_ack  output  1  one-cycle completion pulse
- cpu_stall  output  1  cpu_req & ~cpu_ack; freezes PC, IF_ID, ID_EX and EX_MEM
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  same as the cpu_* ports, for the debug requester
- mem_addr  output  ADDR_W  to DM MemAddr
- mem_wdata  output  DATA_W  to DM MemWriteData
- mem_we  output  1  to DM MemWrite
- mem_rdata  input  DATA_W  from DM MemReadData; combinational in mem_addr

## Operation
- States: IDLE, BUSY, DONE. State is encoded in 2 bits.
- In IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester not served last (round-robin).
  - On grant: latch owner, we, addr and wdata into internal registers, clear cnt, go to BUSY.
- In BUSY:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched_we & (cnt == 0), so each write occurs exactly once.
  - cnt increments each cycle.
  - At cnt == MEM_LAT-1: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then go to DONE.
- In DONE:
  - The owner's ack is 1 for this cycle only.
  - last_owner <= owner.
  - Next state is IDLE unconditionally. Requests sampled in DONE are ignored.
- A requester that still has req high in the cycle after its ack is issuing a new transaction.
- Outside BUSY: mem_we = 0, and mem_addr/mem_wdata hold their last latched values.
- Request inputs are ignored while not in IDLE. Changing addr/we/wdata after grant has no effect.
- cpu_stall is combinational from cpu_req and cpu_ack. All other outputs are registered or derived from registered state.

## Timing
- Request first seen high in IDLE at edge k:
  - BUSY occupies cycles k+1 .. k+MEM_LAT.
  - ack is high in cycle k+MEM_LAT+1.
  - Latency is MEM_LAT+1 cycles. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Default MEM_LAT = 2: a CPU load stalls the pipeline 3 cycles from request to ack, inclusive of the ack cycle's release.
- Simultaneous requests are granted alternately. A continuously requesting pair therefore interleaves cpu, dbg, cpu, ...
- Reset values:
  - state = IDLE, cnt = 0, last_owner = dbg (so the CPU wins the first tie).
  - cpu_rdata = 0, dbg_rdata = 0, cpu_ack = 0, dbg_ack = 0, mem_we = 0.
  - latched addr/wdata = 0.
- Reset mid-operation (BUSY or DONE): the transaction is aborted with no ack. mem_we drops in the cycle reset is sampled. The requester must reissue.
- MEM_LAT = 1: BUSY lasts one cycle, and the write and the read capture occur in the same cycle.
- cnt width is 4 bits and never wraps within one transaction.

## Structure
- Shared package dm_arb_pkg holds:
  - state encoding constants IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - owner constants OWN_CPU = 1'b0, OWN_DBG = 1'b1.
- One sub-module, rr_pick2: combinational two-way round-robin pick from (cpu_req, dbg_req, last_owner), producing grant_valid and grant_owner.
- Everything else (FSM, counter, latches, rdata registers) lives in dm_arbiter.

## Test plan
- Reset then CPU read: cpu_req = 1, cpu_addr = 0x10 with DM[0x10] = 0xDEADBEEF.
  - cpu_ack is high exactly in cycle 3 after the request edge, with cpu_rdata = 0xDEADBEEF.
  - cpu_stall is high in cycles 0–2 and low at ack.
- CPU write: addr 0x20, data 0x12345678.
  - mem_we is high for exactly one cycle with mem_addr = 0x20.
  - A subsequent read returns 0x12345678.
- Simultaneous cpu_req and dbg_req held high for 4 transactions.
  - Grant order is cpu, dbg, cpu, dbg.
  - Each ack is one cycle wide, with 4 cycles between successive acks.
- Debug write issued while a CPU access is in BUSY.
  - The debug write waits and is granted in the IDLE cycle after cpu_ack.
  - cpu_rdata is unaffected by the debug access.
- rst asserted in BUSY cycle 1 of a CPU write.
  - No ack is produced, mem_we = 0 from the next cycle, and all outputs equal their reset values.
  - After reissue, the access completes normally.
- MEM_LAT = 1 build: a read completes with ack in cycle 2. Back-to-back CPU reads acknowledge every 3 cycles.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM state and owner encodings for the data-memory arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick between the CPU and debug requesters
//   cpu_req, dbg_req : pending requests
//   last_owner       : requester served most recently (loses a tie)
//   grant_valid      : at least one request pending
//   grant_owner      : OWN_CPU or OWN_DBG
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = cpu_req | dbg_req;
        grant_owner = (cpu_req & dbg_req) ? ~last_owner : (dbg_req ? OWN_DBG : OWN_CPU);
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port data memory between the MEM stage and a debug port
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_ack, cpu_stall : pipeline MEM-stage requester
//   dbg_req/we/addr/wdata -> dbg_rdata, dbg_ack            : debug/loader requester
//   mem_addr, mem_wdata, mem_we <- mem_rdata                : DM port (read is combinational)
//   Each access holds DM for MEM_LAT cycles, then acks for one cycle.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic              owner, last_owner, lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant_valid, grant_owner, last_beat;

    rr_pick2 u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    assign last_beat = cnt == 4'(MEM_LAT - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state == IDLE ? (grant_valid ? BUSY : IDLE)
                  : state == BUSY ? (last_beat ? DONE : BUSY)
                  : IDLE;
        // the write strobe only on the first busy beat so each write lands once
        mem_we    = (state == BUSY) & lat_we & (cnt == 4'd0);
        cpu_ack   = (state == DONE) & (owner == OWN_CPU);
        dbg_ack   = (state == DONE) & (owner == OWN_DBG);
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            owner      <= OWN_CPU;
            last_owner <= OWN_DBG;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner     <= grant_owner;
                lat_we    <= grant_owner ? dbg_we : cpu_we;
                lat_addr  <= grant_owner ? dbg_addr : cpu_addr;
                lat_wdata <= grant_owner ? dbg_wdata : cpu_wdata;
                cnt       <= 4'd0;
            end
            if (state == BUSY) begin
                cnt <= cnt + 4'd1;
                if (last_beat && !lat_we) begin
                    if (owner == OWN_DBG) dbg_rdata <= mem_rdata;
                    else                  cpu_rdata <= mem_rdata;
                end
            end
            if (state == DONE) last_owner <= owner;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a transaction-level model
module tb_dm_arbiter;

    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, dbg_ack, cpu_stall, mem_we;

    bit [31:0] dm [256];
    assign mem_rdata = dm[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) dm[mem_addr[9:2]] <= mem_wdata;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(M)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // second build with single-cycle memory, reads only from a synthetic address-derived DM
    logic        c1_req = 1'b0;
    logic [31:0] c1_addr = '0;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        c1_ack, c1_stall, d1_ack, m1_we;
    assign m1_rdata = m1_addr ^ 32'hA5A5_0000;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(32'h0),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack), .cpu_stall(c1_stall),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_rdata(d1_rdata), .dbg_ack(d1_ack),
        .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we), .mem_rdata(m1_rdata)
    );

    // transaction-level model: one access at a time, granted at an edge, acked M edges later
    int          e = 0, next_free = 0, t_edge = 0, n_cmp = 0, n_err = 0, n_we = 0;
    bit          have_txn = 1'b0, t_own = 1'b0, t_we = 1'b0, last = 1'b1;
    logic [31:0] t_rd = '0, exp_crd = '0, exp_drd = '0, exp_addr = '0, exp_wdata = '0, we_addr = '0;
    bit [31:0]   ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit ec, ed;
        if (!rst && !have_txn && e + 1 >= next_free && (cpu_req || dbg_req)) begin
            t_own     = (cpu_req && dbg_req) ? !last : dbg_req;
            t_edge    = e + 1;
            have_txn  = 1'b1;
            last      = t_own;
            next_free = e + 3 + M;
            t_we      = t_own ? dbg_we : cpu_we;
            exp_addr  = t_own ? dbg_addr : cpu_addr;
            exp_wdata = t_own ? dbg_wdata : cpu_wdata;
            t_rd      = ref_mem[exp_addr[9:2]];
            if (t_we) ref_mem[exp_addr[9:2]] = exp_wdata;
        end
        if (rst) begin
            have_txn = 1'b0; last = 1'b1; exp_crd = '0; exp_drd = '0;
            exp_addr = '0; exp_wdata = '0; next_free = e + 2;
        end
        @(posedge clk);
        e++;
        #1;
        ec = have_txn && e == t_edge + M && !t_own;
        ed = have_txn && e == t_edge + M && t_own;
        if (ec && !t_we) exp_crd = t_rd;
        if (ed && !t_we) exp_drd = t_rd;
        chk("cpu_ack", 32'(cpu_ack), 32'(ec));
        chk("dbg_ack", 32'(dbg_ack), 32'(ed));
        chk("mem_we", 32'(mem_we), 32'(have_txn && t_we && e == t_edge));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ec));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("dbg_rdata", dbg_rdata, exp_drd);
        if (mem_we) begin n_we++; we_addr = mem_addr; end
        if (ec || ed) have_txn = 1'b0;
    endtask

    task automatic wait_ack(input bit d, output int n);
        n = 0;
        do begin step(); n++; end while (!(d ? dbg_ack : cpu_ack) && n < 40);
        n_cmp++;
        assert (d ? dbg_ack : cpu_ack) else begin
            n_err++;
            $error("FAIL ack_timeout: observed no ack after %0d cycles, expected an ack", n);
        end
    endtask

    initial begin
        int n;
        int ae [4];
        bit ao [4];
        step();
        step();
        rst = 1'b0;
        chk("reset_mem_we", 32'(mem_we), 32'h0);
        chk("reset_cpu_ack", 32'(cpu_ack), 32'h0);

        // loader puts DEADBEEF at 0x10
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
        wait_ack(1'b1, n);
        chk("dbg_wr_lat", n, M + 1);
        dbg_req = 1'b0;
        step();

        // CPU read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        wait_ack(1'b0, n);
        chk("cpu_rd_lat", n, M + 1);
        chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
        chk("stall_at_ack", 32'(cpu_stall), 32'h0);
        cpu_req = 1'b0;
        step();

        // CPU write then read back
        n_we = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
        wait_ack(1'b0, n);
        cpu_req = 1'b0;
        step();
        chk("wr_we_count", n_we, 1);
        chk("wr_we_addr", we_addr, 32'h20);
        cpu_req = 1'b1; cpu_we = 1'b0;
        wait_ack(1'b0, n);
        chk("rdback_data", cpu_rdata, 32'h1234_5678);
        cpu_req = 1'b0;
        step();

        // a debug access so the CPU wins the following tie
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        wait_ack(1'b1, n);
        chk("dbg_rd_data", dbg_rdata, 32'h1234_5678);
        dbg_req = 1'b0;
        step();

        // both requesters held: alternate grants, fixed spacing
        cpu_req = 1'b1; cpu_addr = 32'h10; dbg_req = 1'b1; dbg_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin step(); n++; end while (!(cpu_ack || dbg_ack) && n < 40);
            ao[i] = dbg_ack;
            ae[i] = e;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        for (int i = 0; i < 4; i++) chk("rr_owner", 32'(ao[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) chk("rr_gap", ae[i] - ae[i-1], M + 2);

        // debug write arriving while the CPU is busy waits for the next idle cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'hCAFE_F00D;
        wait_ack(1'b0, n);
        chk("busy_cpu_lat", n, M);
        cpu_req = 1'b0;
        wait_ack(1'b1, n);
        chk("dbg_wait_gap", n, M + 2);
        chk("cpu_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        dbg_req = 1'b0;
        step();

        // reset in the second busy cycle of a CPU write aborts it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h0BAD_F00D;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ack", 32'(cpu_ack), 32'h0);
        chk("abort_mem_we", 32'(mem_we), 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_cpu_rdata", cpu_rdata, 32'h0);
        wait_ack(1'b0, n);
        chk("reissue_lat", n, M + 1);
        cpu_we = 1'b0;
        step();
        step();
        wait_ack(1'b0, n);
        chk("reissue_rdback", cpu_rdata, 32'h0BAD_F00D);
        cpu_req = 1'b0;
        step();

        // random traffic from both requesters; fields scrambled after grant must not matter
        for (int i = 0; i < 400; i++) begin
            step();
            if (cpu_ack || !cpu_req) begin
                cpu_req = cpu_ack ? 1'($urandom_range(1)) : ($urandom_range(3) == 0);
                cpu_we = 1'($urandom_range(1)); cpu_addr = 32'($urandom_range(15)) << 2; cpu_wdata = $urandom;
            end else if (have_txn && !t_own) begin
                cpu_we = 1'($urandom_range(1)); cpu_addr = 32'($urandom_range(15)) << 2; cpu_wdata = $urandom;
            end
            if (dbg_ack || !dbg_req) begin
                dbg_req = dbg_ack ? 1'($urandom_range(1)) : ($urandom_range(3) == 0);
                dbg_we = 1'($urandom_range(1)); dbg_addr = 32'($urandom_range(15)) << 2; dbg_wdata = $urandom;
            end else if (have_txn && t_own) begin
                dbg_we = 1'($urandom_range(1)); dbg_addr = 32'($urandom_range(15)) << 2; dbg_wdata = $urandom;
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_ack) cpu_req = 1'b0;
            if (dbg_ack) dbg_req = 1'b0;
        end
        chk("drained", 32'({cpu_req, dbg_req}), 32'h0);

        // single-cycle memory build: ack in cycle 2, then every 3 cycles
        c1_req = 1'b1; c1_addr = 32'h44;
        n = 0;
        do begin step(); n++; end while (!c1_ack && n < 20);
        chk("lat1_first", n, 2);
        chk("lat1_rdata", c1_rdata, 32'h44 ^ 32'hA5A5_0000);
        chk("lat1_stall", 32'(c1_stall), 32'h0);
        for (int i = 0; i < 2; i++) begin
            c1_addr = 32'h48 + 32'(i * 4);
            n = 0;
            do begin step(); n++; end while (!c1_ack && n < 20);
            chk("lat1_gap", n, 3);
            chk("lat1_rdata_b2b", c1_rdata, (32'h48 + 32'(i * 4)) ^ 32'hA5A5_0000);
        end
        c1_req = 1'b0;
        step();
        chk("lat1_dbg_ack", 32'(d1_ack), 32'h0);
        chk("lat1_dbg_rdata", d1_rdata, 32'h0);
        chk("lat1_mem_we", 32'(m1_we), 32'h0);
        chk("lat1_mem_wdata", m1_wdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
